// File: rtl/cw305_ascon_out_collector.sv
// Collects the bit-serial Ascon ciphertext/tag streams into parallel registers
// and reports a done/error verdict once the bridge goes idle.
module cw305_ascon_out_collector #(
  parameter int unsigned pDATA_WIDTH = 128,
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pCNT_WIDTH  = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   busy_i,
  input  logic [pADDR_WIDTH-1:0] waddr_i,
  input  logic                   val_i,
  input  logic                   dout_i,
  input  logic                   tagout_i,
  output logic [pDATA_WIDTH-1:0] ct_o,
  output logic [pDATA_WIDTH-1:0] tag_o,
  output logic [pCNT_WIDTH-1:0]  cnt_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic                   dup_o,
  output logic                   oor_o
);

  localparam int unsigned IDX_W = $clog2(pDATA_WIDTH);
  localparam logic [pADDR_WIDTH:0] ADDR_LIMIT = (pADDR_WIDTH+1)'(pDATA_WIDTH);
  localparam logic [pCNT_WIDTH-1:0] CNT_FULL = pCNT_WIDTH'(pDATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  state_t                 state;
  logic [pDATA_WIDTH-1:0] mask;
  logic                   busy_q;

  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             busy_fall;

  // Upper address bits only matter for the range test; the index uses the low bits.
  assign in_range  = {1'b0, waddr_i} < ADDR_LIMIT;
  assign idx       = waddr_i[IDX_W-1:0];
  assign busy_fall = busy_q && !busy_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      mask   <= '0;
      busy_q <= 1'b0;
      ct_o   <= '0;
      tag_o  <= '0;
      cnt_o  <= '0;
      done_o <= 1'b0;
      err_o  <= 1'b0;
      dup_o  <= 1'b0;
      oor_o  <= 1'b0;
    end else begin
      busy_q <= busy_i;
      // start_i wins over any capture or end-of-run event in the same cycle.
      if (start_i) begin
        state  <= S_COLLECT;
        mask   <= '0;
        ct_o   <= '0;
        tag_o  <= '0;
        cnt_o  <= '0;
        done_o <= 1'b0;
        err_o  <= 1'b0;
        dup_o  <= 1'b0;
        oor_o  <= 1'b0;
      end else begin
        case (state)
          S_COLLECT: begin
            if (val_i) begin
              if (in_range) begin
                ct_o[idx]  <= dout_i;
                tag_o[idx] <= tagout_i;
                if (mask[idx]) begin
                  dup_o <= 1'b1;
                end else begin
                  mask[idx] <= 1'b1;
                  if (cnt_o != CNT_FULL) cnt_o <= cnt_o + pCNT_WIDTH'(1);
                end
              end else begin
                oor_o <= 1'b1;
              end
            end
            if (busy_fall) state <= S_CHECK;
          end
          S_CHECK: begin
            if (cnt_o == CNT_FULL && !dup_o && !oor_o) begin
              state  <= S_DONE;
              done_o <= 1'b1;
            end else begin
              state <= S_ERR;
              err_o <= 1'b1;
            end
          end
          S_IDLE, S_DONE, S_ERR: state <= state;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
